// File: rtl/adc_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : adc_seq_pkg
// Description : Shared definitions for the ADC conversion sequencer and the
//               chip-level control register file: phase encodings, the
//               combined phase/GAP state record and the phase-length clamp.
// Revision    : 1.0 - initial release
// ============================================================================
package adc_seq_pkg;

    // Sequencer phases. Every active phase is followed by one GAP cycle,
    // which is carried as a separate flag so the phase being closed out is
    // still known while all strobes are low.
    typedef enum logic [2:0] {
        PH_IDLE   = 3'd0,
        PH_INIT   = 3'd1,
        PH_SAMP   = 3'd2,
        PH_COMP   = 3'd3,
        PH_UPDATE = 3'd4
    } phase_e;

    typedef struct packed {
        phase_e phase;  // current (or just-finished, while gap=1) phase
        logic   gap;    // 1: non-overlap cycle after 'phase', all strobes low
    } seq_state_t;

    // Width used for the generic clamp helper; callers cast to their own width.
    localparam int unsigned CLAMP_W = 32;

    // A programmed phase length of zero still yields a one-cycle strobe.
    function automatic logic [CLAMP_W-1:0] clamp_len(input logic [CLAMP_W-1:0] t);
        return (t == '0) ? CLAMP_W'(1) : t;
    endfunction

endpackage : adc_seq_pkg
`default_nettype wire

// File: rtl/adc_phase_timer.sv
`default_nettype none
// ============================================================================
// Module      : adc_phase_timer
// Description : Down-counter shared by all sequencer phases. Loaded with the
//               (already clamped, >= 1) phase length on phase entry, it flags
//               the final cycle of the phase.
// Ports       : clk      - system clock, rising edge
//               rst_n    - asynchronous active-low reset
//               load     - load load_val on this edge (phase entry)
//               load_val - phase length in cycles, must be >= 1
//               last     - high during the last cycle of the phase
// Revision    : 1.0 - initial release
// ============================================================================
module adc_phase_timer #(
    parameter int TW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [TW-1:0] load_val,
    output logic          last
);

    logic [TW-1:0] cnt_q;
    logic [TW-1:0] cnt_d;

    // The count equals the number of strobe cycles still to go including
    // the current one, so the final cycle is the one where it reads 1.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - TW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last = (cnt_q == TW'(1));

endmodule : adc_phase_timer
`default_nettype wire

// File: rtl/adc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : adc_sequencer
// Description : SAR ADC conversion controller. Generates the non-overlapping
//               INIT / SAMP / COMP / UPDATE strobes for the ADC core, collects
//               one comparator decision per bit (MSB first) and presents the
//               result word on a valid/ready interface.
// Ports       : clk, rst_n          - clock / async active-low reset
//               start, cont, abort  - conversion control
//               t_init..t_update    - phase lengths in cycles (0 acts as 1)
//               comp_out            - comparator decision from the core
//               seq_init..seq_update- registered phase strobes (clock gating)
//               busy                - high while not IDLE
//               result, result_valid, result_ready - result handshake
//               overrun             - sticky: unaccepted result overwritten
// Revision    : 1.0 - initial release
// ============================================================================
module adc_sequencer
    import adc_seq_pkg::*;
#(
    parameter int NBITS = 16,   // comparisons per conversion, must be >= 2
    parameter int TW    = 8     // width of the phase-length inputs
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             cont,
    input  logic             abort,
    input  logic [TW-1:0]    t_init,
    input  logic [TW-1:0]    t_samp,
    input  logic [TW-1:0]    t_comp,
    input  logic [TW-1:0]    t_update,
    input  logic             comp_out,
    output logic             seq_init,
    output logic             seq_samp,
    output logic             seq_comp,
    output logic             seq_update,
    output logic             busy,
    output logic [NBITS-1:0] result,
    output logic             result_valid,
    input  logic             result_ready,
    output logic             overrun
);

    localparam int             BW       = (NBITS > 1) ? $clog2(NBITS) : 1;
    localparam logic [BW-1:0]  LAST_BIT = BW'(NBITS - 1);

    // Clamp a programmed length to at least one cycle at this block's width.
    function automatic logic [TW-1:0] phase_len(input logic [TW-1:0] t);
        return TW'(clamp_len(CLAMP_W'(t)));
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    seq_state_t        state_q,      state_d;
    logic              seq_init_q,   seq_init_d;
    logic              seq_samp_q,   seq_samp_d;
    logic              seq_comp_q,   seq_comp_d;
    logic              seq_update_q, seq_update_d;
    logic              busy_q,       busy_d;
    logic [BW-1:0]     bit_q,        bit_d;
    logic [NBITS-1:0]  shift_q,      shift_d;
    logic [NBITS-1:0]  result_q,     result_d;
    logic              valid_q,      valid_d;
    logic              overrun_q,    overrun_d;
    logic              restart_q,    restart_d;   // continuous-mode restart pending

    logic              tmr_load;
    logic [TW-1:0]     tmr_val;
    logic              tmr_last;

    adc_phase_timer #(
        .TW (TW)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .last     (tmr_last)
    );

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        seq_init_d   = seq_init_q;
        seq_samp_d   = seq_samp_q;
        seq_comp_d   = seq_comp_q;
        seq_update_d = seq_update_q;
        bit_d        = bit_q;
        shift_d      = shift_q;
        result_d     = result_q;
        valid_d      = valid_q;
        overrun_d    = overrun_q;
        restart_d    = restart_q;
        tmr_load     = 1'b0;
        tmr_val      = '0;

        // Downstream consumed the result this cycle.
        if (valid_q && result_ready) begin
            valid_d = 1'b0;
        end

        if (abort) begin
            // Abort wins over everything: drop to IDLE with strobes low,
            // forget any pending restart, and leave the result interface
            // exactly as it was.
            state_d      = '{phase: PH_IDLE, gap: 1'b0};
            seq_init_d   = 1'b0;
            seq_samp_d   = 1'b0;
            seq_comp_d   = 1'b0;
            seq_update_d = 1'b0;
            bit_d        = '0;
            restart_d    = 1'b0;
            valid_d      = valid_q;
        end else begin
            unique case (state_q.phase)
                PH_IDLE: begin
                    if (start || restart_q) begin
                        state_d    = '{phase: PH_INIT, gap: 1'b0};
                        seq_init_d = 1'b1;
                        tmr_load   = 1'b1;
                        tmr_val    = phase_len(t_init);
                        restart_d  = 1'b0;
                    end
                end

                default: begin
                    if (!state_q.gap) begin
                        // Active phase: close it out on the timer's last cycle.
                        if (tmr_last) begin
                            state_d.gap  = 1'b1;
                            seq_init_d   = 1'b0;
                            seq_samp_d   = 1'b0;
                            seq_comp_d   = 1'b0;
                            seq_update_d = 1'b0;
                            // Decisions shift in from the LSB side so that
                            // after NBITS bits the first one sits at the MSB.
                            if (state_q.phase == PH_COMP) begin
                                shift_d = {shift_q[NBITS-2:0], comp_out};
                            end
                        end
                    end else begin
                        // Gap cycle: move on to the next phase.
                        state_d.gap = 1'b0;
                        case (state_q.phase)
                            PH_INIT: begin
                                state_d.phase = PH_SAMP;
                                seq_samp_d    = 1'b1;
                                tmr_load      = 1'b1;
                                tmr_val       = phase_len(t_samp);
                            end
                            PH_SAMP: begin
                                state_d.phase = PH_COMP;
                                seq_comp_d    = 1'b1;
                                tmr_load      = 1'b1;
                                tmr_val       = phase_len(t_comp);
                            end
                            PH_COMP: begin
                                state_d.phase = PH_UPDATE;
                                seq_update_d  = 1'b1;
                                tmr_load      = 1'b1;
                                tmr_val       = phase_len(t_update);
                            end
                            PH_UPDATE: begin
                                if (bit_q == LAST_BIT) begin
                                    // Conversion complete.
                                    state_d.phase = PH_IDLE;
                                    bit_d         = '0;
                                    result_d      = shift_q;
                                    valid_d       = 1'b1;
                                    // A result accepted in this very cycle
                                    // is not an overrun.
                                    if (valid_q && !result_ready) begin
                                        overrun_d = 1'b1;
                                    end
                                    // Restart waits one IDLE cycle so the
                                    // completion cycle is always visible.
                                    restart_d     = cont;
                                end else begin
                                    state_d.phase = PH_COMP;
                                    bit_d         = bit_q + BW'(1);
                                    seq_comp_d    = 1'b1;
                                    tmr_load      = 1'b1;
                                    tmr_val       = phase_len(t_comp);
                                end
                            end
                            default: begin
                                // Unreachable encoding: recover to IDLE.
                                state_d = '{phase: PH_IDLE, gap: 1'b0};
                                bit_d   = '0;
                            end
                        endcase
                    end
                end
            endcase
        end

        busy_d = (state_d.phase != PH_IDLE);
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= '{phase: PH_IDLE, gap: 1'b0};
            seq_init_q   <= 1'b0;
            seq_samp_q   <= 1'b0;
            seq_comp_q   <= 1'b0;
            seq_update_q <= 1'b0;
            busy_q       <= 1'b0;
            bit_q        <= '0;
            shift_q      <= '0;
            result_q     <= '0;
            valid_q      <= 1'b0;
            overrun_q    <= 1'b0;
            restart_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            seq_init_q   <= seq_init_d;
            seq_samp_q   <= seq_samp_d;
            seq_comp_q   <= seq_comp_d;
            seq_update_q <= seq_update_d;
            busy_q       <= busy_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            result_q     <= result_d;
            valid_q      <= valid_d;
            overrun_q    <= overrun_d;
            restart_q    <= restart_d;
        end
    end

    // Strobes gate clocks in the core: straight from flops, no logic after.
    assign seq_init     = seq_init_q;
    assign seq_samp     = seq_samp_q;
    assign seq_comp     = seq_comp_q;
    assign seq_update   = seq_update_q;
    assign busy         = busy_q;
    assign result       = result_q;
    assign result_valid = valid_q;
    assign overrun      = overrun_q;

endmodule : adc_sequencer
`default_nettype wire

// File: tb/tb_adc_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_adc_sequencer
// Description : Directed self-checking bench for adc_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adc_sequencer;

    localparam int NBITS = 16;
    localparam int TW    = 8;

    logic             clk = 1'b0;
    logic             rst_n, start, cont, abort, comp_out, result_ready;
    logic [TW-1:0]    t_init, t_samp, t_comp, t_update;
    logic             seq_init, seq_samp, seq_comp, seq_update;
    logic             busy, result_valid, overrun;
    logic [NBITS-1:0] result;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    adc_sequencer #(.NBITS(NBITS), .TW(TW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .cont         (cont),
        .abort        (abort),
        .t_init       (t_init),
        .t_samp       (t_samp),
        .t_comp       (t_comp),
        .t_update     (t_update),
        .comp_out     (comp_out),
        .seq_init     (seq_init),
        .seq_samp     (seq_samp),
        .seq_comp     (seq_comp),
        .seq_update   (seq_update),
        .busy         (busy),
        .result       (result),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .overrun      (overrun)
    );

    // Background monitor: strobe overlap and missing gap between phases.
    int         overlap_err = 0;
    int         gap_err     = 0;
    logic [3:0] mon_prev    = 4'b0;
    always @(negedge clk) begin : mon
        logic [3:0] v;
        v = {seq_init, seq_samp, seq_comp, seq_update};
        if ($countones(v) > 1) overlap_err++;
        if (v != 4'b0 && mon_prev != 4'b0 && v != mon_prev) gap_err++;
        mon_prev = v;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Results of the last run_conv call. Strobe index: 3 init, 2 samp,
    // 1 comp, 0 update.
    int         cycles;
    int         ncomp;
    int         wmin[4];
    int         wmax[4];
    logic [3:0] first_vec;

    // Optionally pulse start, then follow one conversion at negedges until
    // busy drops, driving comp_out from pat (MSB first) and measuring strobe
    // widths. abort_bit >= 0 raises abort+start during that bit's COMP.
    task automatic run_conv(input logic [NBITS-1:0] pat, input bit do_start,
                            input bit start_in_samp, input int abort_bit);
        logic [3:0] v, prev;
        int run[4];
        cycles = 0; ncomp = 0; prev = 4'b0; first_vec = 4'b0;
        for (int i = 0; i < 4; i++) begin
            run[i] = 0; wmin[i] = 1000000; wmax[i] = 0;
        end
        start = do_start;
        @(negedge clk);
        while (busy && cycles < 4000) begin
            v = {seq_init, seq_samp, seq_comp, seq_update};
            start = 1'b0;
            abort = 1'b0;
            cycles++;
            if (cycles == 1) first_vec = v;
            for (int i = 0; i < 4; i++) begin
                if (v[i]) run[i]++;
                else if (prev[i]) begin
                    if (run[i] < wmin[i]) wmin[i] = run[i];
                    if (run[i] > wmax[i]) wmax[i] = run[i];
                    run[i] = 0;
                end
            end
            if (v[1] && !prev[1]) begin
                if (ncomp == abort_bit) begin
                    abort = 1'b1;
                    start = 1'b1;
                end
                if (ncomp < NBITS) comp_out = pat[NBITS-1-ncomp];
                ncomp++;
            end
            if (start_in_samp && v[2] && !prev[2]) start = 1'b1;
            prev = v;
            @(negedge clk);
        end
        start = 1'b0;
        abort = 1'b0;
        check("conv_bounded", (cycles < 4000) ? 32'd1 : 32'd0, 32'd1);
    endtask

    initial begin : stim
        int bc;
        int guard;
        rst_n = 1'b0; start = 1'b0; cont = 1'b0; abort = 1'b0;
        comp_out = 1'b0; result_ready = 1'b0;
        t_init = 8'd1; t_samp = 8'd1; t_comp = 8'd1; t_update = 8'd1;

        // ---- Reset state ----
        repeat (3) @(negedge clk);
        check("rst_busy",    busy, 0);
        check("rst_seq",     {seq_init, seq_samp, seq_comp, seq_update}, 0);
        check("rst_result",  result, 0);
        check("rst_valid",   result_valid, 0);
        check("rst_overrun", overrun, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // ---- Single conversion, all lengths 1, alternating decisions ----
        run_conv(16'hAAAA, 1'b1, 1'b0, -1);
        check("c1_first_init", first_vec, 4'b1000);
        check("c1_cycles",  cycles, 68);
        check("c1_ncomp",   ncomp, 16);
        check("c1_result",  result, 16'hAAAA);
        check("c1_valid",   result_valid, 1);
        check("c1_overrun", overrun, 0);
        check("c1_w_init",  wmax[3], 1);
        check("c1_w_samp",  wmax[2], 1);
        check("c1_w_comp",  wmax[1], 1);
        check("c1_w_upd",   wmax[0], 1);
        check("c1_overlap", overlap_err, 0);
        check("c1_gap",     gap_err, 0);

        // ---- Handshake: one ready cycle drops valid, result holds ----
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
        check("hs_valid",  result_valid, 0);
        check("hs_result", result, 16'hAAAA);

        // ---- Programmed lengths 3/5/2/0 ----
        t_init = 8'd3; t_samp = 8'd5; t_comp = 8'd2; t_update = 8'd0;
        run_conv(16'h1234, 1'b1, 1'b0, -1);
        check("c2_cycles",   cycles, 90);
        check("c2_w_init",   wmin[3], 3);
        check("c2_w_samp",   wmin[2], 5);
        check("c2_wmin_comp", wmin[1], 2);
        check("c2_wmax_comp", wmax[1], 2);
        check("c2_wmin_upd", wmin[0], 1);
        check("c2_wmax_upd", wmax[0], 1);
        check("c2_result",   result, 16'h1234);
        check("c2_overrun",  overrun, 0);
        check("c2_gap",      gap_err, 0);
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;

        // ---- Continuous mode, ready held low: overrun ----
        t_init = 8'd1; t_samp = 8'd1; t_comp = 8'd1; t_update = 8'd1;
        cont = 1'b1;
        run_conv(16'hC3C3, 1'b1, 1'b0, -1);
        check("ct1_result",  result, 16'hC3C3);
        check("ct1_valid",   result_valid, 1);
        check("ct1_overrun", overrun, 0);
        cont = 1'b0;
        run_conv(16'h5A5A, 1'b0, 1'b0, -1);
        check("ct2_restart_init", first_vec, 4'b1000);
        check("ct2_cycles",  cycles, 68);
        check("ct2_result",  result, 16'h5A5A);
        check("ct2_overrun", overrun, 1);
        bc = 0;
        repeat (10) begin @(negedge clk); bc += int'(busy); end
        check("ct2_no_third", bc, 0);

        // ---- Asynchronous reset in the middle of UPDATE ----
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        guard = 0;
        while (!seq_update && guard < 200) begin @(negedge clk); guard++; end
        check("rst_upd_seen", seq_update, 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy",    busy, 0);
        check("arst_seq",     {seq_init, seq_samp, seq_comp, seq_update}, 0);
        check("arst_result",  result, 0);
        check("arst_valid",   result_valid, 0);
        check("arst_overrun", overrun, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // ---- Clean conversion after reset, continuous with ready high ----
        result_ready = 1'b1;
        cont = 1'b1;
        run_conv(16'h9669, 1'b1, 1'b0, -1);
        check("cr1_cycles",  cycles, 68);
        check("cr1_result",  result, 16'h9669);
        check("cr1_valid",   result_valid, 1);
        cont = 1'b0;
        run_conv(16'h3CA5, 1'b0, 1'b0, -1);
        check("cr2_result",  result, 16'h3CA5);
        check("cr2_valid",   result_valid, 1);
        check("cr2_overrun", overrun, 0);
        @(negedge clk);
        check("cr2_accepted", result_valid, 0);
        result_ready = 1'b0;

        // ---- start pulsed during SAMP is ignored ----
        run_conv(16'h0F0F, 1'b1, 1'b1, -1);
        check("ss_cycles",  cycles, 68);
        check("ss_result",  result, 16'h0F0F);
        check("ss_valid",   result_valid, 1);
        bc = 0;
        repeat (10) begin @(negedge clk); bc += int'(busy); end
        check("ss_one_result", bc, 0);

        // ---- Abort together with start during bit 7 COMP ----
        run_conv(16'hFFFF, 1'b1, 1'b0, 7);
        check("ab_ncomp",   ncomp, 8);
        check("ab_seq",     {seq_init, seq_samp, seq_comp, seq_update}, 0);
        check("ab_busy",    busy, 0);
        check("ab_valid",   result_valid, 1);
        check("ab_result",  result, 16'h0F0F);
        check("ab_overrun", overrun, 0);
        bc = 0;
        repeat (10) begin @(negedge clk); bc += int'(busy); end
        check("ab_no_start", bc, 0);
        check("final_overlap", overlap_err, 0);
        check("final_gap",     gap_err, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_adc_sequencer
`default_nettype wire
